// File: rtl/rv_pkg.sv
// Shared types and constants for the write-back stage.
// Holds the datapath widths, the load funct3 codes and the write-back entry record.
// Has no logic and no state.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int MUL_W = 64;
    localparam int NREGS = 32;
    localparam int REG_W = $clog2(NREGS);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

    // Which source owns the register-file write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MUL  = 2'd1,
        SRC_SKID = 2'd2,
        SRC_PIPE = 2'd3
    } wb_src_e;

endpackage

// File: rtl/rv_writeback_if.sv
// Bundle of every result, load, multiply and register-file signal of the write-back stage.
// master drives results and loads; slave is the write-back block, which drives the regfile port.
// Status outputs: busy_o scoreboard, mul_busy_o, stall_o (skid full) and sticky err_o.
interface rv_writeback_if;
    import rv_pkg::*;

    logic             alu_valid_i;
    logic [REG_W-1:0] alu_rd_i;
    logic [XLEN-1:0]  alu_data_i;
    logic             ld_valid_i;
    logic [REG_W-1:0] ld_rd_i;
    logic [2:0]       ld_funct3_i;
    logic [1:0]       ld_addr_lo_i;
    logic [XLEN-1:0]  ld_rdata_i;
    logic             mul_start_i;
    logic [REG_W-1:0] mul_rd_i;
    logic             mul_valid_i;
    logic [MUL_W-1:0] mul_data_i;
    logic             rf_write_en;
    logic [REG_W-1:0] rf_write_reg;
    logic [XLEN-1:0]  rf_write_data;
    logic [NREGS-1:0] busy_o;
    logic             mul_busy_o;
    logic             stall_o;
    logic             err_o;

    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_valid_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i, ld_rdata_i,
        output mul_start_i, mul_rd_i, mul_valid_i, mul_data_i,
        input  rf_write_en, rf_write_reg, rf_write_data,
        input  busy_o, mul_busy_o, stall_o, err_o
    );

    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_valid_i, ld_rd_i, ld_funct3_i, ld_addr_lo_i, ld_rdata_i,
        input  mul_start_i, mul_rd_i, mul_valid_i, mul_data_i,
        output rf_write_en, rf_write_reg, rf_write_data,
        output busy_o, mul_busy_o, stall_o, err_o
    );

endinterface

// File: rtl/rv_load_extend.sv
// Load alignment: selects the byte or halfword from the raw word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none; ld_err flags misaligned accesses and unknown funct3 codes.
// Ports: funct3/addr_lo/rdata in; extended data and ld_err out.
module rv_load_extend
    import rv_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            ld_err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        data   = '0;
        ld_err = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data   = {{(XLEN-16){half_sel[15]}}, half_sel};
                ld_err = addr_lo[0];
            end
            F3_LHU: begin
                data   = {{(XLEN-16){1'b0}}, half_sel};
                ld_err = addr_lo[0];
            end
            F3_LW: begin
                data   = rdata;
                ld_err = (addr_lo != 2'b00);
            end
            default: ld_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// Write-back arbiter: multiply result > skid entry > new ALU/load result onto the regfile port.
// Latency: 1 cycle from winning source to rf_write_*; at most one write per cycle.
// Backpressure: a losing pipe result parks in a 1-entry skid; stall_o is high while it is full.
// Ports: clk, rst (sync, active high), wb (slave side of rv_writeback_if).
module rv_writeback
    import rv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    rv_writeback_if.slave  wb
);

    // Registered state
    logic             skid_vld_q;
    wb_entry_t        skid_q;
    logic             mul_busy_q;
    logic [REG_W-1:0] mul_tag_q;
    logic [NREGS-1:0] busy_q;
    logic             err_q;
    logic             out_en_q;
    wb_entry_t        out_q;

    // Load path
    logic [XLEN-1:0]  ld_data;
    logic             ld_err;

    rv_load_extend u_load_extend (
        .funct3  (wb.ld_funct3_i),
        .addr_lo (wb.ld_addr_lo_i),
        .rdata   (wb.ld_rdata_i),
        .data    (ld_data),
        .ld_err  (ld_err)
    );

    // Upper product bits are intentionally discarded.
    logic unused_mul_hi;
    assign unused_mul_hi = ^wb.mul_data_i[MUL_W-1:XLEN];

    // Source qualification
    logic      m_fire;       // multiply completes this cycle
    logic      m_wr;         // ... and needs the write port (rd != 0)
    logic      p_any;
    logic      p_both;
    logic      p_ok;         // pipe result is legal and consumed
    logic      p_wr;         // ... and needs the write port
    wb_entry_t p_entry;
    wb_entry_t m_entry;
    logic      start_ok;
    logic      err_set;

    assign m_fire   = wb.mul_valid_i & mul_busy_q;
    assign m_wr     = m_fire & (mul_tag_q != '0);
    assign p_any    = wb.alu_valid_i | wb.ld_valid_i;
    assign p_both   = wb.alu_valid_i & wb.ld_valid_i;
    // Skid full means stall_o was high, so anything presented now is dropped.
    assign p_ok     = p_any & ~p_both & ~skid_vld_q & ~(wb.ld_valid_i & ld_err);
    assign p_wr     = p_ok & (p_entry.rd != '0);
    assign m_entry  = '{rd: mul_tag_q, data: wb.mul_data_i[XLEN-1:0]};
    // A new multiply may start when idle or in the same cycle the old one retires.
    assign start_ok = wb.mul_start_i & (~mul_busy_q | m_fire);

    assign err_set  = (p_any & skid_vld_q)
                    | p_both
                    | (wb.ld_valid_i & ld_err)
                    | (wb.mul_start_i & ~start_ok)
                    | (wb.mul_valid_i & ~mul_busy_q);

    always_comb begin
        p_entry = '0;
        if (wb.alu_valid_i) begin
            p_entry = '{rd: wb.alu_rd_i, data: wb.alu_data_i};
        end else begin
            p_entry = '{rd: wb.ld_rd_i, data: ld_data};
        end
    end

    // Arbitration
    wb_src_e   src;
    wb_entry_t win;
    logic      skid_load;
    logic      skid_vld_d;

    always_comb begin
        src = SRC_NONE;
        win = '0;
        if (m_wr) begin
            src = SRC_MUL;
            win = m_entry;
        end else if (skid_vld_q) begin
            src = SRC_SKID;
            win = skid_q;
        end else if (p_wr) begin
            src = SRC_PIPE;
            win = p_entry;
        end
    end

    // p_wr already implies the skid is empty, so only a multiply can displace it.
    assign skid_load  = p_wr & (src != SRC_PIPE);
    assign skid_vld_d = skid_load | (skid_vld_q & (src != SRC_SKID));

    // Scoreboard: retire first, then start, so a same-rd back-to-back leaves the bit set.
    logic [NREGS-1:0] busy_d;
    logic             mul_busy_d;

    always_comb begin
        busy_d     = busy_q;
        mul_busy_d = mul_busy_q;
        if (m_fire) begin
            busy_d[mul_tag_q] = 1'b0;
            mul_busy_d        = 1'b0;
        end
        if (start_ok) begin
            mul_busy_d = 1'b1;
            if (wb.mul_rd_i != '0) begin
                busy_d[wb.mul_rd_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            mul_busy_q <= 1'b0;
            mul_tag_q  <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
            out_en_q   <= 1'b0;
            out_q      <= '0;
        end else begin
            skid_vld_q <= skid_vld_d;
            if (skid_load) begin
                skid_q <= p_entry;
            end
            mul_busy_q <= mul_busy_d;
            if (start_ok) begin
                mul_tag_q <= wb.mul_rd_i;
            end
            busy_q   <= busy_d;
            err_q    <= err_q | err_set;
            out_en_q <= (src != SRC_NONE);
            out_q    <= win;
        end
    end

    assign wb.rf_write_en   = out_en_q;
    assign wb.rf_write_reg  = out_q.rd;
    assign wb.rf_write_data = out_q.data;
    assign wb.busy_o        = busy_q;
    assign wb.mul_busy_o    = mul_busy_q;
    assign wb.stall_o       = skid_vld_q;
    assign wb.err_o         = err_q;

endmodule

// File: tb/tb_rv_writeback.sv
// Bench for rv_writeback: vector table, multi-cycle sequences, randomized run against a model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stimulus honours stall_o most of the time and occasionally violates it.
module tb_rv_writeback;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv_writeback_if bus();

    rv_writeback dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid_i  = 0; bus.alu_rd_i = 0; bus.alu_data_i = 0;
        bus.ld_valid_i   = 0; bus.ld_rd_i = 0; bus.ld_funct3_i = 0;
        bus.ld_addr_lo_i = 0; bus.ld_rdata_i = 0;
        bus.mul_start_i  = 0; bus.mul_rd_i = 0;
        bus.mul_valid_i  = 0; bus.mul_data_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_data;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] rdata;
        logic        en;
        logic [4:0]  rg;
        logic [31:0] dat;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    // ---------------- reference model ----------------
    logic        m_held_v;
    wb_entry_t   m_held;
    logic        m_mbusy;
    logic [4:0]  m_tag;
    logic [31:0] m_busy;
    logic        m_err;
    logic        e_en;
    wb_entry_t   e_out;

    function automatic logic load_model(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic [31:0] w, output logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (w >> (16 * (lo / 2))) & 32'hFFFF;
        d = 0;
        case (f3)
            3'd0: begin d = (b >= 128) ? b - 256 : b; return 1; end
            3'd4: begin d = b; return 1; end
            3'd1: begin d = (h >= 32768) ? h - 65536 : h; return (lo % 2) == 0; end
            3'd5: begin d = h; return (lo % 2) == 0; end
            3'd2: begin d = w; return lo == 0; end
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_held_v = 0; m_held = '0; m_mbusy = 0; m_tag = 0; m_busy = 0; m_err = 0;
        e_en = 0; e_out = '0;
    endtask

    // One cycle of the write-back rules applied to whatever is on the bus now.
    task automatic model_step();
        wb_entry_t   cands[$];
        logic        mul_done;
        logic [31:0] ld_d;
        logic        ld_ok;
        wb_entry_t   req;
        logic        req_v;

        mul_done = bus.mul_valid_i && m_mbusy;
        if (bus.mul_valid_i && !m_mbusy) m_err = 1;

        req_v = 0;
        req   = '0;
        ld_ok = load_model(bus.ld_funct3_i, bus.ld_addr_lo_i, bus.ld_rdata_i, ld_d);
        if (bus.alu_valid_i && bus.ld_valid_i) m_err = 1;
        else if ((bus.alu_valid_i || bus.ld_valid_i) && m_held_v) m_err = 1;
        else if (bus.ld_valid_i && !ld_ok) m_err = 1;
        else if (bus.alu_valid_i) begin req_v = 1; req = '{rd: bus.alu_rd_i, data: bus.alu_data_i}; end
        else if (bus.ld_valid_i) begin req_v = 1; req = '{rd: bus.ld_rd_i, data: ld_d}; end

        if (mul_done && m_tag != 0) cands.push_back('{rd: m_tag, data: bus.mul_data_i[31:0]});
        if (m_held_v) cands.push_back(m_held);
        if (req_v && req.rd != 0) cands.push_back(req);

        e_en  = cands.size() > 0;
        e_out = e_en ? cands[0] : '0;
        m_held_v = cands.size() > 1;
        if (m_held_v) m_held = cands[1];

        if (mul_done) begin
            m_busy = m_busy & ~(32'd1 << m_tag);
            m_mbusy = 0;
        end
        if (bus.mul_start_i) begin
            if (m_mbusy) m_err = 1;
            else begin
                m_mbusy = 1;
                m_tag = bus.mul_rd_i;
                if (bus.mul_rd_i != 0) m_busy = m_busy | (32'd1 << bus.mul_rd_i);
            end
        end
    endtask

    initial begin
        rst = 0;
        idle();

        // Reset state
        do_reset();
        chk("reset_en", bus.rf_write_en, 0);
        chk("reset_status", {bus.busy_o, bus.mul_busy_o, bus.stall_o, bus.err_o}, 0);

        // Single-cycle vectors: alu/load in, one registered write (or error) out.
        vecs.push_back('{1, 5, 32'h1234, 0, 0, 3'd0, 2'd0, 32'h0, 1, 5, 32'h1234, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 2, 3'd0, 2'd3, 32'h80FF_FF7F, 1, 2, 32'hFFFF_FF80, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 2, 3'd4, 2'd3, 32'h80FF_FF7F, 1, 2, 32'h0000_0080, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 2, 3'd1, 2'd1, 32'h80FF_FF7F, 0, 0, 32'h0, 1});
        vecs.push_back('{1, 0, 32'hDEAD, 0, 0, 3'd0, 2'd0, 32'h0, 0, 0, 32'h0, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 3, 3'd1, 2'd2, 32'h80FF_FF7F, 1, 3, 32'hFFFF_80FF, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 3, 3'd5, 2'd0, 32'h80FF_FF7F, 1, 3, 32'h0000_FF7F, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 9, 3'd2, 2'd0, 32'h80FF_FF7F, 1, 9, 32'h80FF_FF7F, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 9, 3'd2, 2'd2, 32'h80FF_FF7F, 0, 0, 32'h0, 1});
        vecs.push_back('{0, 0, 32'h0, 1, 9, 3'd3, 2'd0, 32'h80FF_FF7F, 0, 0, 32'h0, 1});
        vecs.push_back('{1, 6, 32'h5, 1, 7, 3'd2, 2'd0, 32'h1, 0, 0, 32'h0, 1});
        vecs.push_back('{0, 0, 32'h0, 1, 31, 3'd0, 2'd1, 32'h80FF_FF7F, 1, 31, 32'hFFFF_FFFF, 0});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 3'd4, 2'd0, 32'h80FF_FF7F, 1, 1, 32'h0000_007F, 0});

        foreach (vecs[i]) begin
            do_reset();
            bus.alu_valid_i  = vecs[i].alu_v;
            bus.alu_rd_i     = vecs[i].alu_rd;
            bus.alu_data_i   = vecs[i].alu_data;
            bus.ld_valid_i   = vecs[i].ld_v;
            bus.ld_rd_i      = vecs[i].ld_rd;
            bus.ld_funct3_i  = vecs[i].f3;
            bus.ld_addr_lo_i = vecs[i].lo;
            bus.ld_rdata_i   = vecs[i].rdata;
            tick();
            idle();
            chk($sformatf("vec%0d_en", i), bus.rf_write_en, vecs[i].en);
            if (vecs[i].en)
                chk($sformatf("vec%0d_wr", i), {bus.rf_write_reg, bus.rf_write_data},
                    {vecs[i].rg, vecs[i].dat});
            chk($sformatf("vec%0d_err", i), bus.err_o, vecs[i].err);
            chk($sformatf("vec%0d_stall", i), bus.stall_o, 0);
        end

        // Multiply with a 10-cycle gap; only the low word is written.
        do_reset();
        bus.mul_start_i = 1; bus.mul_rd_i = 7;
        tick(); idle();
        chk("mul_busy_set", {bus.busy_o, bus.mul_busy_o}, {32'h80, 1'b1});
        repeat (10) tick();
        chk("mul_busy_hold", {bus.busy_o, bus.mul_busy_o, bus.rf_write_en}, {32'h80, 1'b1, 1'b0});
        bus.mul_valid_i = 1; bus.mul_data_i = 64'h1_0000_0003;
        tick(); idle();
        chk("mul_write", {bus.rf_write_en, bus.rf_write_reg, bus.rf_write_data}, {1'b1, 5'd7, 32'h3});
        chk("mul_clear", {bus.busy_o, bus.mul_busy_o, bus.err_o}, 0);

        // Multiply and ALU collide: ALU goes through the skid one cycle later.
        do_reset();
        bus.mul_start_i = 1; bus.mul_rd_i = 6;
        tick(); idle();
        bus.mul_valid_i = 1; bus.mul_data_i = 64'h55;
        bus.alu_valid_i = 1; bus.alu_rd_i = 4; bus.alu_data_i = 32'hAA;
        tick(); idle();
        chk("collide_n1", {bus.rf_write_en, bus.rf_write_reg, bus.rf_write_data, bus.stall_o},
            {1'b1, 5'd6, 32'h55, 1'b1});
        tick();
        chk("collide_n2", {bus.rf_write_en, bus.rf_write_reg, bus.rf_write_data, bus.stall_o},
            {1'b1, 5'd4, 32'hAA, 1'b0});
        chk("collide_err", bus.err_o, 0);

        // Presenting a result while stalled is dropped and flagged.
        do_reset();
        bus.mul_start_i = 1; bus.mul_rd_i = 6;
        tick(); idle();
        bus.mul_valid_i = 1; bus.mul_data_i = 64'h1;
        bus.alu_valid_i = 1; bus.alu_rd_i = 4; bus.alu_data_i = 32'h44;
        tick(); idle();
        bus.alu_valid_i = 1; bus.alu_rd_i = 10; bus.alu_data_i = 32'h10;
        tick(); idle();
        chk("stall_viol_skid", {bus.rf_write_en, bus.rf_write_reg, bus.err_o}, {1'b1, 5'd4, 1'b1});
        tick();
        chk("stall_viol_drop", bus.rf_write_en, 0);

        // Back-to-back multiplies to the same register keep the busy bit set.
        do_reset();
        bus.mul_start_i = 1; bus.mul_rd_i = 8;
        tick(); idle();
        bus.mul_valid_i = 1; bus.mul_data_i = 64'h77;
        bus.mul_start_i = 1; bus.mul_rd_i = 8;
        tick(); idle();
        chk("b2b_write", {bus.rf_write_en, bus.rf_write_reg, bus.rf_write_data}, {1'b1, 5'd8, 32'h77});
        chk("b2b_busy", {bus.busy_o, bus.mul_busy_o, bus.err_o}, {32'h100, 1'b1, 1'b0});
        bus.mul_valid_i = 1; bus.mul_data_i = 64'h88;
        tick(); idle();
        chk("b2b_second", {bus.rf_write_en, bus.rf_write_data, bus.busy_o}, {1'b1, 32'h88, 32'h0});

        // Start while busy is ignored.
        do_reset();
        bus.mul_start_i = 1; bus.mul_rd_i = 11;
        tick(); idle();
        bus.mul_start_i = 1; bus.mul_rd_i = 12;
        tick(); idle();
        chk("start_busy", {bus.busy_o, bus.mul_busy_o, bus.err_o}, {32'h800, 1'b1, 1'b1});
        bus.mul_valid_i = 1; bus.mul_data_i = 64'h9;
        tick(); idle();
        chk("start_busy_tag", {bus.rf_write_en, bus.rf_write_reg}, {1'b1, 5'd11});

        // Reset mid-multiply: a late done pulse is discarded.
        do_reset();
        bus.mul_start_i = 1; bus.mul_rd_i = 7;
        tick(); idle();
        do_reset();
        chk("rst_mid_clear", {bus.busy_o, bus.mul_busy_o, bus.err_o}, 0);
        bus.mul_valid_i = 1; bus.mul_data_i = 64'h5;
        tick(); idle();
        chk("rst_mid_late", {bus.rf_write_en, bus.busy_o, bus.err_o}, {1'b0, 32'h0, 1'b1});

        // Randomized run against the model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [2:0] f3_tab [6];
            f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
            idle();
            if ($urandom_range(249) == 0) begin
                rst = 1;
                tick();
                rst = 0;
                model_reset();
            end else begin
                bus.alu_valid_i = ($urandom_range(2) == 0);
                bus.alu_rd_i    = 5'($urandom);
                bus.alu_data_i  = $urandom;
                bus.ld_valid_i  = ($urandom_range(3) == 0);
                bus.ld_rd_i     = 5'($urandom);
                bus.ld_funct3_i = f3_tab[$urandom_range(5)];
                bus.ld_addr_lo_i = 2'($urandom);
                if ($urandom_range(9) < 8) begin
                    if (bus.ld_funct3_i == 3'd2) bus.ld_addr_lo_i = 0;
                    if (bus.ld_funct3_i == 3'd1 || bus.ld_funct3_i == 3'd5)
                        bus.ld_addr_lo_i[0] = 0;
                    if (bus.ld_funct3_i == 3'd3) bus.ld_funct3_i = 3'd0;
                end
                bus.ld_rdata_i = $urandom;
                if (bus.alu_valid_i && bus.ld_valid_i && $urandom_range(9) != 0) bus.ld_valid_i = 0;
                if (m_held_v && $urandom_range(9) != 0) begin
                    bus.alu_valid_i = 0;
                    bus.ld_valid_i  = 0;
                end
                if (m_mbusy) begin
                    bus.mul_valid_i = ($urandom_range(4) == 0);
                    bus.mul_start_i = bus.mul_valid_i ? ($urandom_range(2) == 0)
                                                      : ($urandom_range(39) == 0);
                end else begin
                    bus.mul_valid_i = ($urandom_range(149) == 0);
                    bus.mul_start_i = ($urandom_range(5) == 0);
                end
                bus.mul_rd_i   = 5'($urandom);
                bus.mul_data_i = {$urandom, $urandom};
                model_step();
                tick();
                chk("rand_en", bus.rf_write_en, e_en);
                if (e_en) chk("rand_wr", {bus.rf_write_reg, bus.rf_write_data}, {e_out.rd, e_out.data});
                chk("rand_state", {bus.busy_o, bus.mul_busy_o, bus.stall_o, bus.err_o},
                    {m_busy, m_mbusy, m_held_v, m_err});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
